// File: rtl/mac_accumulator_4.sv
// mac_accumulator_4: sequential multiply-accumulate stage.
//
// Accepts 4-bit operand pairs over a valid/ready handshake. Each accepted pair
// is multiplied by multiplier_4, and the 8-bit product is registered. The
// products are then summed into an ACC_W-bit accumulator. A dot product ends on
// in_last or on the N_TERMS-th accepted term. The result, its term count and a
// sticky overflow flag are held on a valid/ready output until the consumer
// takes them.
//
// Optional build macro: MAC_SATURATE_EN
//   defined   - an addition whose true sum exceeds 2^ACC_W-1 clamps to all ones
//   undefined - the accumulator wraps modulo 2^ACC_W
//   In both builds out_ovf reports that the sum exceeded 2^ACC_W-1.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE/RUN only)
//   a, b       4-bit unsigned operands
//   in_last    final term of the current dot product
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_acc    accumulated result (ACC_W bits)
//   out_cnt    number of terms in the result
//   out_ovf    accumulation exceeded 2^ACC_W-1 at least once

// 4x4 unsigned combinational multiplier (shift-and-add).
module multiplier_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    always_comb begin
        p = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p + ({4'd0, a} << i);
            end
        end
    end
endmodule

module mac_accumulator_4 #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned N_TERMS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   a,
    input  logic [3:0]                   b,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_acc,
    output logic [$clog2(N_TERMS+1)-1:0] out_cnt,
    output logic                         out_ovf
);
    localparam int unsigned CntW = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        prod_q, prod_d;
    logic              prod_vld_q, prod_vld_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CntW-1:0]   out_cnt_q, out_cnt_d;
    logic              out_ovf_q, out_ovf_d;

    logic [7:0]        mul_p;
    logic              accept;
    logic [CntW-1:0]   cnt_inc;
    logic              eff_last;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_sum;

    multiplier_4 u_mul (
        .a (a),
        .b (b),
        .p (mul_p)
    );

    assign in_ready = (state_q == StIdle) || (state_q == StRun);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;
    // The N_TERMS-th term closes the dot product even without in_last.
    assign eff_last = in_last || (cnt_inc == CntW'(N_TERMS));

    // One extra bit exposes the carry out of the accumulator.
    assign sum   = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_q};
    assign carry = sum[ACC_W];

`ifdef MAC_SATURATE_EN
    // Once clamped, acc stays all ones: any further non-zero product carries
    // again, and a zero product leaves it unchanged.
    assign acc_sum = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_sum = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        last_d      = last_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            prod_d     = mul_p;
            prod_vld_d = 1'b1;
            last_d     = eff_last;
            cnt_d      = cnt_inc;
        end

        unique case (state_q)
            StIdle, StRun: begin
                // Non-final products are folded in while further terms arrive.
                if (prod_vld_q && !last_q) begin
                    acc_d = acc_sum;
                    ovf_d = ovf_q | carry;
                end
                if (accept) begin
                    state_d = eff_last ? StFlush : StRun;
                end
            end
            StFlush: begin
                // The final product goes straight to the output register.
                out_acc_d   = (prod_vld_q && last_q) ? acc_sum : acc_q;
                out_ovf_d   = ovf_q | ((prod_vld_q && last_q) ? carry : 1'b0);
                out_cnt_d   = cnt_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                last_d      = 1'b0;
                state_d     = StHold;
            end
            StHold: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator_4.sv
// Directed bench for mac_accumulator_4: a default-width instance (ACC_W=16)
// and an ACC_W=8 instance for the overflow case.
module tb_mac_accumulator_4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_acc;
    logic [3:0]  out_cnt;
    logic        out_ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [3:0]  a8 = '0;
    logic [3:0]  b8 = '0;
    logic        in_last8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  out_acc8;
    logic [3:0]  out_cnt8;
    logic        out_ovf8;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mac_accumulator_4 #(.ACC_W(16), .N_TERMS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    mac_accumulator_4 #(.ACC_W(8), .N_TERMS(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .in_last   (in_last8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_acc   (out_acc8),
        .out_cnt   (out_cnt8),
        .out_ovf   (out_ovf8)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and outputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one term and hold it until accepted (bounded).
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tl);
        int guard = 0;
        a        = ta;
        b        = tb;
        in_last  = tl;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] held;

        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_acc", 32'(out_acc), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        step();

        // Single term 15*15 with last: out_valid two cycles after accept
        send(4'd15, 4'd15, 1'b1);
        check("t2_valid_t1", 32'(out_valid), 0);
        check("t2_ready_flush", 32'(in_ready), 0);
        step();
        check("t2_valid_t2", 32'(out_valid), 1);
        check("t2_acc", 32'(out_acc), 225);
        check("t2_cnt", 32'(out_cnt), 1);
        check("t2_ovf", 32'(out_ovf), 0);
        take_result();
        check("t2_valid_drop", 32'(out_valid), 0);
        check("t2_ready_back", 32'(in_ready), 1);

        // Back-to-back terms: 12 + 30 + 56 = 98
        send(4'd3, 4'd4, 1'b0);
        send(4'd5, 4'd6, 1'b0);
        send(4'd7, 4'd8, 1'b1);
        check("t3_ready_flush", 32'(in_ready), 0);
        wait_result();
        check("t3_acc", 32'(out_acc), 98);
        check("t3_cnt", 32'(out_cnt), 3);

        // HOLD with out_ready low; inputs offered must be ignored
        held     = out_acc[7:0];
        a        = 4'd9;
        b        = 4'd9;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_acc_stable", 32'(out_acc), 32'(held));
            check("t4_ready_low", 32'(in_ready), 0);
            check("t4_valid_held", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result();
        check("t4_valid_drop", 32'(out_valid), 0);
        check("t4_ready_back", 32'(in_ready), 1);
        send(4'd1, 4'd2, 1'b1);
        wait_result();
        check("t4_next_acc", 32'(out_acc), 2);
        check("t4_next_cnt", 32'(out_cnt), 1);
        take_result();

        // Reset mid-RUN with acc=50; partial sum discarded
        send(4'd5, 4'd10, 1'b0);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("t1_valid", 32'(out_valid), 0);
        check("t1_acc", 32'(out_acc), 0);
        check("t1_cnt", 32'(out_cnt), 0);
        check("t1_ovf", 32'(out_ovf), 0);
        check("t1_ready", 32'(in_ready), 1);
        send(4'd2, 4'd3, 1'b1);
        wait_result();
        check("t1_acc_new", 32'(out_acc), 6);
        take_result();

        // N_TERMS implicit last, 9th pair waits for the output handshake
        for (int i = 0; i < 8; i++) send(4'd1, 4'd1, 1'b0);
        a        = 4'd2;
        b        = 4'd2;
        in_last  = 1'b1;
        in_valid = 1'b1;
        step();
        check("t6_valid", 32'(out_valid), 1);
        check("t6_acc", 32'(out_acc), 8);
        check("t6_cnt", 32'(out_cnt), 8);
        check("t6_ready_hold", 32'(in_ready), 0);
        step();
        step();
        check("t6_acc_held", 32'(out_acc), 8);
        take_result();
        check("t6_ready_idle", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t6_ninth_flush", 32'(in_ready), 0);
        step();
        check("t6_ninth_valid", 32'(out_valid), 1);
        check("t6_ninth_acc", 32'(out_acc), 4);
        check("t6_ninth_cnt", 32'(out_cnt), 1);
        take_result();

        // ACC_W=8 overflow: 225 + 225 = 450
        a8        = 4'd15;
        b8        = 4'd15;
        in_last8  = 1'b0;
        in_valid8 = 1'b1;
        step();
        in_last8  = 1'b1;
        step();
        in_valid8 = 1'b0;
        in_last8  = 1'b0;
        step();
        check("t5_valid", 32'(out_valid8), 1);
`ifdef MAC_SATURATE_EN
        check("t5_acc_sat", 32'(out_acc8), 255);
`else
        check("t5_acc_wrap", 32'(out_acc8), 194);
`endif
        check("t5_ovf", 32'(out_ovf8), 1);
        check("t5_cnt", 32'(out_cnt8), 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
